// File: rtl/chan_mux_pkg.sv
// +---------------------------------------------------------------------------+
// | chan_mux_pkg : shared types and limits for the chan_mux_n channel mux     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package chan_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int N_CH_MAX = 16;

endpackage

`default_nettype wire

// File: rtl/chan_mux_rr_arb.sv
// +---------------------------------------------------------------------------+
// | chan_mux_rr_arb : round-robin search over in_valid starting at ptr        |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module chan_mux_rr_arb #(
  parameter int N_CH  = 7,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  in_valid,
  input  logic             advance,
  output logic [SEL_W-1:0] grant,
  output logic             grant_vld
);

  localparam logic [SEL_W-1:0] C_LAST = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]   C_N_CH = (SEL_W + 1)'(N_CH);

  logic [SEL_W-1:0] ptr_q, ptr_d;

  // Walk offsets from the far end back to ptr so the nearest valid channel wins.
  always_comb begin
    logic [SEL_W:0] idx;
    idx       = '0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_q} + (SEL_W + 1)'(i);
      if (idx >= C_N_CH) begin
        idx = idx - C_N_CH;
      end
      if (in_valid[idx[SEL_W-1:0]]) begin
        grant     = idx[SEL_W-1:0];
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant == C_LAST) ? '0 : grant + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/chan_mux_n.sv
// +---------------------------------------------------------------------------+
// | chan_mux_n : N-channel registered mux, fixed-select or round-robin scan.  |
// | Optional sticky select-range error output when CHAN_MUX_N_ERR_EN is set.  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module chan_mux_n
  import chan_mux_pkg::*;
#(
  parameter int N_CH  = 7,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        select,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_ch
`ifdef CHAN_MUX_N_ERR_EN
  ,
  output logic                    err
`endif
);

  localparam logic [SEL_W:0] C_N_CH = (SEL_W + 1)'(N_CH);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;

  logic             rr_mode, sel_oob, load_en, xfer, cand_ok;
  logic [SEL_W-1:0] cand, grant;
  logic             grant_vld;
  logic [N_CH-1:0]  in_ready_w;
  logic [WIDTH-1:0] cand_data;

  assign rr_mode = (mode_e'(mode) == MODE_RR);
  assign sel_oob = ({1'b0, select} >= C_N_CH);
  assign load_en = !out_valid_q || out_ready;
  assign cand    = rr_mode ? grant : select;
  assign cand_ok = rr_mode ? grant_vld : !sel_oob;

  chan_mux_rr_arb #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .advance   (rr_mode && xfer),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  // Fixed mode offers ready regardless of in_valid; scan mode only to the grant.
  always_comb begin
    in_ready_w = '0;
    if (!rst && cand_ok) begin
      for (int k = 0; k < N_CH; k++) begin
        if (cand == SEL_W'(k)) begin
          in_ready_w[k] = load_en;
        end
      end
    end
  end

  always_comb begin
    cand_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (cand == SEL_W'(k)) begin
        cand_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer     = |(in_ready_w & in_valid);
  assign in_ready = in_ready_w;

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = cand_data;
      out_ch_d    = cand;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

`ifdef CHAN_MUX_N_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (!rr_mode && sel_oob) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_chan_mux_n.sv
// +---------------------------------------------------------------------------+
// | tb_chan_mux_n : randomized bench for chan_mux_n (N_CH=7, WIDTH=8)         |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_chan_mux_n;

  localparam int N = 7;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           mode;
  logic [2:0]     select;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [2:0]     out_ch;
`ifdef CHAN_MUX_N_ERR_EN
  logic           err;
`endif

  chan_mux_n #(.N_CH(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .select    (select),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
`ifdef CHAN_MUX_N_ERR_EN
    ,
    .err       (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: the word held at the output and the scan pointer.
  bit       m_known = 0;
  bit       m_ov;
  int       m_od;
  int       m_och;
  int       m_ptr;
  bit       m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_ch(input int k, input logic [7:0] v);
    in_data[k*W +: W] = v;
  endtask

  // Which channel the spec says is offered this cycle (-1 = none).
  function automatic int model_cand();
    int c;
    c = -1;
    if (rst) return -1;
    if (mode == 1'b0) begin
      if (int'(select) < N) c = int'(select);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[(m_ptr + i) % N]) begin
          c = (m_ptr + i) % N;
          break;
        end
      end
    end
    return c;
  endfunction

  // One clock: compare everything against the model, then advance the model.
  task automatic cyc();
    int          c;
    bit          load_en;
    logic [N-1:0] er;
    bit          xfer;
    #1;
    c       = model_cand();
    load_en = !m_ov || out_ready;
    er      = '0;
    if (c >= 0 && load_en) er[c] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    if (m_known) begin
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("out_data", 32'(out_data), 32'(m_od));
      chk("out_ch", 32'(out_ch), 32'(m_och));
`ifdef CHAN_MUX_N_ERR_EN
      chk("err", 32'(err), 32'(m_err));
`endif
    end
    xfer = (c >= 0) && load_en && in_valid[c];
    if (rst) begin
      m_ov = 0; m_od = 0; m_och = 0; m_ptr = 0; m_err = 0;
      m_known = 1;
    end else begin
      if (xfer) begin
        m_od  = int'(in_data[c*W +: W]);
        m_och = c;
        m_ov  = 1;
        if (mode) m_ptr = (c + 1) % N;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (mode == 1'b0 && int'(select) >= N) m_err = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  int seq[8] = '{0, 1, 2, 3, 4, 5, 6, 0};

  initial begin
    rst = 1'b1; mode = 1'b0; select = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc();
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_ch", 32'(out_ch), 32'h0);

    // Round-robin scan over all-valid channels, ptr starts at 0 after reset.
    mode = 1'b1; in_valid = 7'h7F; out_ready = 1'b1;
    for (int k = 0; k < N; k++) set_ch(k, 8'(8'h10 + k));
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("rr_seq_ch", 32'(out_ch), 32'(seq[i]));
    end

    // Move ptr to 3, then ch6 and ch2 alternate from there.
    in_valid = 7'h04;
    cyc();
    in_valid = 7'h44;
    #1;
    chk("rr44_ready_a", 32'(in_ready), 32'h40);
    cyc();
    chk("rr44_ch_a", 32'(out_ch), 32'd6);
    chk("rr44_ready_b", 32'(in_ready), 32'h04);
    cyc();
    chk("rr44_ch_b", 32'(out_ch), 32'd2);
    in_valid = 7'h7F;
    #1;
    chk("rr_ptr_is_3", 32'(in_ready), 32'h08);
    cyc();

    // Fixed select of channel 3.
    mode = 1'b0; select = 3'd3; set_ch(3, 8'hA5); in_valid = 7'h08; out_ready = 1'b1;
    #1;
    chk("fix_ready", 32'(in_ready), 32'h08);
    cyc();
    chk("fix_data", 32'(out_data), 32'hA5);
    chk("fix_ch", 32'(out_ch), 32'd3);
    chk("fix_valid", 32'(out_valid), 32'h1);

    // Backpressure: held word stays, then back-to-back loads.
    select = 3'd1; set_ch(1, 8'h3C); in_valid = 7'h02;
    cyc();
    out_ready = 1'b0; set_ch(1, 8'h77);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_data", 32'(out_data), 32'h3C);
      chk("bp_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    cyc();
    chk("b2b_data_a", 32'(out_data), 32'h77);
    set_ch(1, 8'h88);
    cyc();
    chk("b2b_data_b", 32'(out_data), 32'h88);
    chk("b2b_valid", 32'(out_valid), 32'h1);

    // Out-of-range select blocks everything.
    do_reset();
    select = 3'd7; in_valid = 7'h7F; out_ready = 1'b1;
    #1;
    chk("oob_ready", 32'(in_ready), 32'h0);
    cyc();
    chk("oob_valid", 32'(out_valid), 32'h0);
`ifdef CHAN_MUX_N_ERR_EN
    chk("oob_err", 32'(err), 32'h1);
`endif
    select = 3'd2; in_valid = 7'h00;
    cyc();
`ifdef CHAN_MUX_N_ERR_EN
    chk("oob_err_sticky", 32'(err), 32'h1);
`endif

    // Reset with a held word and a moved ptr.
    mode = 1'b1; in_valid = 7'h10; out_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst2_valid", 32'(out_valid), 32'h0);
    chk("rst2_data", 32'(out_data), 32'h0);
    chk("rst2_ch", 32'(out_ch), 32'h0);
    in_valid = 7'h7F; out_ready = 1'b1;
    #1;
    chk("rst2_ptr0", 32'(in_ready), 32'h01);
    cyc();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      mode      = ($urandom_range(0, 3) != 0);
      select    = 3'($urandom_range(0, 7));
      in_valid  = 7'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = {$urandom, $urandom};
      cyc();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/chan_mux_n.md
CHAN_MUX_N -- requirements
Module: chan_mux_n

Interface
REQ-001 Parameter N_CH, default 7, number of input channels (2..16).
REQ-002 Parameter WIDTH, default 8, data bits per channel.
REQ-003 Parameter SEL_W, default $clog2(N_CH), select/channel-index width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 mode  input  1  0 = fixed select, 1 = round-robin scan.
REQ-008 select  input  SEL_W  channel index used when mode=0.
REQ-009 in_data  input  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 in_valid  input  N_CH  per-channel data-valid.
REQ-011 in_ready  output  N_CH  per-channel accept; at most one bit high per cycle.
REQ-012 out_data  output  WIDTH  registered selected data.
REQ-013 out_valid  output  1  out_data/out_ch hold an untaken word.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 out_ch  output  SEL_W  channel index that sourced out_data.

Function
REQ-016 load_en SHALL equal (!out_valid || out_ready); output register loads only when load_en and an input transfer occurs.
REQ-017 Input transfer on channel k SHALL occur when in_valid[k] && in_ready[k]; output transfer when out_valid && out_ready.
REQ-018 Latency SHALL be 1 cycle input-transfer to out_valid; sustained throughput 1 word/cycle.
REQ-019 mode=0: candidate = select; in_ready[select] = load_en; all other in_ready bits 0; in_ready is independent of in_valid.
REQ-020 mode=0 with select >= N_CH: all in_ready SHALL be 0, no load occurs.
REQ-021 mode=1: candidate = first k with in_valid[k] searching ptr, ptr+1, ... N_CH-1, 0, ... ptr-1; in_ready[candidate] = load_en; no valid channel -> all in_ready 0.
REQ-022 ptr (SEL_W bits, range 0..N_CH-1) SHALL update to (candidate+1) mod N_CH on each mode=1 input transfer, wrapping N_CH-1 -> 0; otherwise hold.
REQ-023 ptr SHALL not change in mode=0; mode switch 0->1 resumes scan from held ptr.
REQ-024 Simultaneous output and input transfer: out register SHALL take new word, out_valid stays 1, no bubble.
REQ-025 Output transfer without input transfer: out_valid SHALL clear next cycle; out_data/out_ch hold last value.
REQ-026 While out_valid && !out_ready, out_data/out_ch/out_valid SHALL be stable; mode/select changes affect only the next load.
REQ-027 in_ready SHALL be purely combinational from mode, select, in_valid, ptr, out_valid, out_ready.

Reset
REQ-028 On rst: out_valid=0, out_data=0, out_ch=0, ptr=0; held word discarded without output transfer.
REQ-029 in_ready SHALL be all 0 while rst is high.

Configuration
REQ-030 With CHAN_MUX_N_ERR_EN defined: extra output err (1 bit) SHALL set sticky when mode=0 and select >= N_CH, cleared only by rst; reset value 0.
REQ-031 Without CHAN_MUX_N_ERR_EN: no err port; out-of-range select silently blocks per REQ-020.

Structure
REQ-032 Package chan_mux_pkg SHALL hold mode enum (MODE_FIXED=0, MODE_RR=1) and the N_CH upper-bound constant.
REQ-033 Round-robin search and ptr SHALL live in sub-module chan_mux_rr_arb (inputs: in_valid, advance; outputs: grant index, grant_vld).
REQ-034 Datapath register and handshake SHALL reside in chan_mux_n.

Verification (N_CH=7, WIDTH=8)
REQ-035 mode=0, select=3, in_data ch3=0xA5, in_valid=7'h08, out_ready=1 -> in_ready=7'h08; next cycle out_data=0xA5, out_ch=3, out_valid=1.
REQ-036 mode=1, in_valid=7'h7F, out_ready=1, 8 cycles -> out_ch sequence 0,1,2,3,4,5,6,0 (wrap).
REQ-037 mode=1, in_valid=7'h44 (ch2, ch6), ptr=3 -> grant ch6 then ch2; ptr ends at 3.
REQ-038 out_ready=0 for 3 cycles after load of 0x3C -> out_data=0x3C stable, in_ready=0; out_ready=1 with in_valid -> back-to-back load, no bubble.
REQ-039 mode=0, select=7 -> in_ready=0 for all, out_valid stays 0; with CHAN_MUX_N_ERR_EN err=1 and remains 1 after select=2.
REQ-040 Assert rst while out_valid=1, out_ready=0 -> next cycle out_valid=0, out_data=0, out_ch=0, ptr=0.
